adder_operand_recover: RTL

Inverse of the registered 7-bit operand adder. Given a transaction carrying the 8-bit sum and one 7-bit operand, the block recovers the other operand (`b = sum - a`) and flags sums that no 7-bit operand could have produced. It is a 2-stage valid/ready pipeline with full throughput and backpressure. It sits on the checking side of the adder datapath and keeps a saturating count of inconsistent transactions.

---
 rtl/adder_operand_recover.sv | 89 ++++++++
 1 files changed

// File: rtl/adder_operand_recover.sv
//==============================================================================
// Module      : adder_operand_recover
// Description : Recovers b = sum - a from an adder transaction through a
//               2-stage valid/ready pipeline and counts out-of-range results.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module adder_operand_recover (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_sum,
    input  logic [6:0] in_a,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] out_b,
    output logic       out_err,
    output logic [7:0] err_cnt
);

    localparam logic [7:0] C_CNT_MAX = 8'hFF;

    logic       r_s1_v;
    logic [7:0] r_s1_sum;
    logic [6:0] r_s1_a;
    logic       r_out_valid;
    logic [6:0] r_out_b;
    logic       r_out_err;
    logic [7:0] r_err_cnt;

    logic       w_s2_adv;
    logic [8:0] w_diff;
    logic       w_err;
    logic       w_deliver;

    assign w_s2_adv  = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_v || w_s2_adv;
    assign w_deliver = r_out_valid && out_ready;

    // Bit 8 flags a negative difference, bit 7 a magnitude above 127.
    assign w_diff = {1'b0, r_s1_sum} - {2'b00, r_s1_a};
    assign w_err  = w_diff[8] | w_diff[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s1_sum <= 8'd0;
            r_s1_a   <= 7'd0;
        end else if (in_ready) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_s1_sum <= in_sum;
                r_s1_a   <= in_a;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_b     <= 7'd0;
            r_out_err   <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_v;
            if (r_s1_v) begin
                r_out_b   <= w_err ? 7'd0 : w_diff[6:0];
                r_out_err <= w_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_deliver && r_out_err && (r_err_cnt != C_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_b     = r_out_b;
    assign out_err   = r_out_err;
    assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire
